// File: rtl/aes_inv_subbytes_serial_pkg.sv
// Shared AES decryption datapath types, FSM encoding and the InvShiftRows byte map.
package aes_dec_pkg;
  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef logic [AES_STATE_W-1:0] aes_state_t;
  typedef logic [7:0]             aes_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } isb_state_e;

  // Output byte 4c+r of InvShiftRows takes input byte 4*((c-r) mod 4)+r.
  function automatic int unsigned inv_shift_idx(input int unsigned k);
    int unsigned c;
    int unsigned r;
    c = k / 4;
    r = k % 4;
    return 4 * ((c + 4 - r) % 4) + r;
  endfunction
endpackage

// File: rtl/aes_inv_subbytes_serial_if.sv
// Block-in / block-out valid-ready bundle for the serial InvSubBytes stage.
interface aes_inv_subbytes_serial_if;
  import aes_dec_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_inv_subbytes_serial_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
module aes_inv_sbox_lut
  import aes_dec_pkg::*;
(
  input  aes_byte_t byte_i,
  output aes_byte_t byte_o
);
  // Entry 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] idx;

  assign idx    = 11'd2047 - {byte_i, 3'b000};
  assign byte_o = INV_SBOX[idx -: 8];
endmodule

// File: rtl/aes_inv_subbytes_serial.sv
// Serial InvSubBytes stage: BYTES_PER_CYCLE inverse S-box lanes over 16/BYTES_PER_CYCLE beats.
// Optional AES_INV_SHIFTROWS_EN folds InvShiftRows into the lane byte select.
module aes_inv_subbytes_serial
  import aes_dec_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  aes_inv_subbytes_serial_if.slave  bus,
  output logic                      busy
);
  localparam int unsigned      BEATS    = AES_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned      CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_illegal
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  isb_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  aes_state_t                      src_q, src_d;
  aes_state_t                      res_q, res_d;
  logic [BYTES_PER_CYCLE-1:0][7:0] lane_in;
  logic [BYTES_PER_CYCLE-1:0][7:0] lane_out;

  function automatic int unsigned src_byte(input int unsigned k);
`ifdef AES_INV_SHIFTROWS_EN
    return inv_shift_idx(k);
`else
    return k;
`endif
  endfunction

  always_comb begin : lane_select
    lane_in = '0;
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      lane_in[j] = src_q[8 * (AES_BYTES - 1 - src_byte(32'(cnt_q) * BYTES_PER_CYCLE + j)) +: 8];
    end
  end

  for (genvar j = 0; j < int'(BYTES_PER_CYCLE); j++) begin : g_lane
    aes_inv_sbox_lut u_lut (
      .byte_i (lane_in[j]),
      .byte_o (lane_out[j])
    );
  end

  always_comb begin : result_update
    res_d = res_q;
    if (state_q == ST_BUSY) begin
      for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
        res_d[8 * (AES_BYTES - 1 - (32'(cnt_q) * BYTES_PER_CYCLE + j)) +: 8] = lane_out[j];
      end
    end
  end

  // DONE with out_ready high accepts a new block in the same cycle, so there is no bubble.
  always_comb begin : fsm_next
    state_d       = state_q;
    cnt_d         = cnt_q;
    src_d         = src_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          src_d   = bus.in_state;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            src_d   = bus.in_state;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign bus.out_state = res_q;
endmodule

// File: tb/tb_aes_inv_subbytes_serial.sv
// Directed bench for aes_inv_subbytes_serial at 1, 4 and 16 lanes (AES_INV_SHIFTROWS_EN aware).
module tb_aes_inv_subbytes_serial;
  localparam logic [127:0] I1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] I4  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] I16 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
`ifdef AES_INV_SHIFTROWS_EN
  localparam logic [127:0] E1  = 128'h52f3a3383009d79ebf366afb8140a5d5;
  localparam logic [127:0] E4  = 128'h7cde43879be3e944342f39cbc48eff82;
  localparam logic [127:0] E16 = 128'h17211426ba2b0c63e177047d5569d67e;
`else
  localparam logic [127:0] E1  = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] E4  = 128'h7ce339829b2fff87348e4344c4dee9cb;
  localparam logic [127:0] E16 = 128'h172b047eba77d626e169146355210c7d;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy1, busy4, busy16;
  int   total = 0;
  int   bad   = 0;

  aes_inv_subbytes_serial_if if1 ();
  aes_inv_subbytes_serial_if if4 ();
  aes_inv_subbytes_serial_if if16 ();

  aes_inv_subbytes_serial #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave), .busy (busy1)
  );
  aes_inv_subbytes_serial #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave), .busy (busy4)
  );
  aes_inv_subbytes_serial #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk (clk), .rst (rst), .bus (if16.slave), .busy (busy16)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [127:0] d);
    case (s)
      1:       begin if1.in_valid  = v; if1.in_state  = d; end
      4:       begin if4.in_valid  = v; if4.in_state  = d; end
      default: begin if16.in_valid = v; if16.in_state = d; end
    endcase
  endtask

  task automatic set_ordy(input int s, input logic r);
    case (s)
      1:       if1.out_ready  = r;
      4:       if4.out_ready  = r;
      default: if16.out_ready = r;
    endcase
  endtask

  function automatic logic get_ov(input int s);
    case (s)
      1:       return if1.out_valid;
      4:       return if4.out_valid;
      default: return if16.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int s);
    case (s)
      1:       return if1.in_ready;
      4:       return if4.in_ready;
      default: return if16.in_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      1:       return busy1;
      4:       return busy4;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [127:0] get_os(input int s);
    case (s)
      1:       return if1.out_state;
      4:       return if4.out_state;
      default: return if16.out_state;
    endcase
  endfunction

  // Presents a block on a negedge, checks in_ready, returns just after the accepting posedge.
  task automatic accept(input int s, input logic [127:0] d, input string tag);
    @(negedge clk);
    set_in(s, 1'b1, d);
    #1;
    check({tag, "_in_ready"}, 128'(get_ir(s)), 128'(1'b1));
    @(posedge clk);
  endtask

  // Cycle 1 is the first cycle after the accepting edge; out_valid must rise at cycle lat.
  task automatic wait_out(input int s, input int lat, input logic [127:0] exp,
                          input string tag, input bit post);
    int cyc;
    @(negedge clk);
    set_in(s, 1'b0, '0);
    #1;
    check({tag, "_busy"}, 128'(get_busy(s)), 128'(1'b1));
    cyc = 1;
    while (!get_ov(s) && cyc < 64) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    check({tag, "_out_state"}, get_os(s), exp);
    if (post) begin
      @(negedge clk);
      #1;
      check({tag, "_valid_drop"}, 128'(get_ov(s)), 128'(1'b0));
      check({tag, "_hold"}, get_os(s), exp);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      set_in((s == 0) ? 1 : (s == 1) ? 4 : 16, 1'b0, '0);
      set_ordy((s == 0) ? 1 : (s == 1) ? 4 : 16, 1'b1);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 128'(get_ir(1)), 128'(1'b1));
    check("rst_out_valid", 128'(get_ov(1)), 128'(1'b0));
    check("rst_busy", 128'(get_busy(1)), 128'(1'b0));
    check("rst_out_state", get_os(1), '0);
    check("rst_out_valid4", 128'(get_ov(4)), 128'(1'b0));
    rst = 1'b0;

    accept(1, I1, "bpc1");
    wait_out(1, 17, E1, "bpc1", 1'b1);

    accept(4, {16{8'h63}}, "bpc4_63");
    wait_out(4, 5, '0, "bpc4_63", 1'b1);
    accept(4, {16{8'hff}}, "bpc4_ff");
    wait_out(4, 5, {16{8'h7d}}, "bpc4_ff", 1'b1);
    accept(4, I4, "bpc4_1x");
    wait_out(4, 5, E4, "bpc4_1x", 1'b1);

    accept(16, I16, "bpc16");
    wait_out(16, 2, E16, "bpc16", 1'b1);

    // Backpressure in DONE, then handshake with a new block in the same cycle.
    set_ordy(1, 1'b0);
    accept(1, I1, "bp");
    wait_out(1, 17, E1, "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid_held", 128'(get_ov(1)), 128'(1'b1));
      check("bp_state_held", get_os(1), E1);
      check("bp_in_ready", 128'(get_ir(1)), 128'(1'b0));
    end
    @(negedge clk);
    set_ordy(1, 1'b1);
    set_in(1, 1'b1, I4);
    #1;
    check("b2b_in_ready", 128'(get_ir(1)), 128'(1'b1));
    @(posedge clk);
    wait_out(1, 17, E4, "b2b", 1'b1);

    // Reset while processing beat 7 discards the block.
    accept(1, {16{8'hff}}, "mid");
    @(negedge clk);
    set_in(1, 1'b0, '0);
    repeat (7) @(negedge clk);
    #1;
    check("mid_busy_beat7", 128'(get_busy(1)), 128'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(get_ir(1)), 128'(1'b1));
    check("mid_rst_out_valid", 128'(get_ov(1)), 128'(1'b0));
    check("mid_rst_busy", 128'(get_busy(1)), 128'(1'b0));
    check("mid_rst_out_state", get_os(1), '0);
    accept(1, I1, "after_rst");
    wait_out(1, 17, E1, "after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
